cu_sequencer: RTL

Multicycle RISC-V control-unit sequencer. Holds the 4-bit control state register, loads it each cycle from `next_state`'s `ns` output, and stalls on memory wait states. Feeds the current state back to `next_state` and decodes it into the datapath control strobes. Sits between `next_state`, the datapath and the memory interface.

---
 rtl/cu_sequencer.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/cu_sequencer.sv
// Multicycle RISC-V control-unit sequencer: state register, memory-wait stalls and strobe decode.
// Optional CU_PERF_EN adds free-running cycle and retired-instruction counters.
module cu_sequencer #(
   parameter logic [3:0] RESET_STATE = 4'd0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  ns,
   output logic [3:0]  state,
   input  logic        mem_ready,
   output logic        mem_req,
   output logic        mem_we,
   output logic        adr_src,
   output logic        ir_write,
   output logic        pc_write,
   output logic        reg_write,
   output logic        branch,
   output logic [1:0]  alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [1:0]  alu_op,
   output logic [1:0]  result_src,
   output logic        instr_done,
`ifdef CU_PERF_EN
   output logic [31:0] cycle_count,
   output logic [31:0] instret_count,
`endif
   output logic        illegal_state
);

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADDR  = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_EXEC_R    = 4'd6,
      S_ALU_WB    = 4'd7,
      S_BRANCH    = 4'd8,
      S_JUMP_ADDR = 4'd9,
      S_JAL       = 4'd10,
      S_AUIPC     = 4'd11,
      S_JALR      = 4'd12,
      S_EXEC_I    = 4'd13
   } state_e;

   state_e state_q, state_d;
   logic   illegal_q, illegal_d;
   logic   done_q, done_d;
   logic   stall;
   logic   ns_bad;

   always_comb begin
      state_d   = state_q;
      illegal_d = illegal_q;
      done_d    = 1'b0;
      stall     = (state_q inside {S_FETCH, S_MEM_READ, S_MEM_WRITE}) && !mem_ready;
      ns_bad    = (ns >= 4'd14);
      // A stalled cycle ignores ns entirely, including an out-of-range value.
      if (!stall) begin
         if (ns_bad) begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
         end else begin
            state_d = state_e'(ns);
            done_d  = (state_q != S_FETCH) && (ns == 4'd0);
         end
      end
   end

`ifdef CU_PERF_EN
   logic [31:0] cycle_q;
   logic [31:0] instret_q;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= state_e'(RESET_STATE);
         illegal_q <= 1'b0;
         done_q    <= 1'b0;
`ifdef CU_PERF_EN
         cycle_q   <= 32'd0;
         instret_q <= 32'd0;
`endif
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
         done_q    <= done_d;
`ifdef CU_PERF_EN
         cycle_q   <= cycle_q + 32'd1;
         instret_q <= instret_q + {31'd0, done_d};
`endif
      end
   end

   assign state         = state_q;
   assign illegal_state = illegal_q;
   assign instr_done    = done_q;
`ifdef CU_PERF_EN
   assign cycle_count   = cycle_q;
   assign instret_count = instret_q;
`endif

   always_comb begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      adr_src    = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      branch     = 1'b0;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      result_src = 2'b00;
      case (state_q)
         S_FETCH: begin
            mem_req    = 1'b1;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            ir_write   = mem_ready;
            pc_write   = mem_ready;
         end
         S_DECODE, S_AUIPC: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
         end
         S_MEM_ADDR: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
         end
         S_MEM_READ: begin
            mem_req = 1'b1;
            adr_src = 1'b1;
         end
         S_MEM_WB: begin
            result_src = 2'b01;
            reg_write  = 1'b1;
         end
         S_MEM_WRITE: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
            adr_src = 1'b1;
         end
         S_EXEC_R: begin
            alu_src_a = 2'b10;
            alu_op    = 2'b10;
         end
         S_EXEC_I: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            alu_op    = 2'b10;
         end
         S_ALU_WB: reg_write = 1'b1;
         S_BRANCH: begin
            alu_src_a = 2'b10;
            alu_op    = 2'b01;
            branch    = 1'b1;
         end
         S_JUMP_ADDR: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b10;
         end
         S_JAL: begin
            pc_write  = 1'b1;
            reg_write = 1'b1;
         end
         S_JALR: begin
            alu_src_a  = 2'b10;
            alu_src_b  = 2'b01;
            result_src = 2'b10;
            pc_write   = 1'b1;
            reg_write  = 1'b1;
         end
         default: ;
      endcase
      // Reset blanks every strobe so no memory access leaks out mid-reset.
      if (reset) begin
         mem_req    = 1'b0;
         mem_we     = 1'b0;
         adr_src    = 1'b0;
         ir_write   = 1'b0;
         pc_write   = 1'b0;
         reg_write  = 1'b0;
         branch     = 1'b0;
         alu_src_a  = 2'b00;
         alu_src_b  = 2'b00;
         alu_op     = 2'b00;
         result_src = 2'b00;
      end
   end

endmodule
